obi_mem_arbiter: RTL and testbench
==================================

// Module: obi_mem_arbiter
// PURPOSE
// Arbitrates the core's OBI instruction and data ports onto one shared memory port.
// It sits between the core fetch/LSU interfaces and the SoC memory.
// An in-order FIFO tracks the source of every outstanding granted request, so responses
// route back to the correct requester (up to DEPTH in flight).
// Data has priority; an anti-starvation counter guarantees instruction fetch progress.
// PARAMETERS
// MEM_W       32  memory data width in bits; power of two, >= 32
// DEPTH       8   max outstanding granted requests; power of two, >= 2
// STARVE_MAX  4   consecutive data grants with fetch pending before fetch is forced
// PORTS
// clk_i           in   1        clock
// rst_i           in   1        synchronous reset, active-high
// instr_req_i     in   1        fetch request
// instr_gnt_o     out  1        fetch grant
// instr_addr_i    in   32       fetch address
// instr_rvalid_o  out  1        fetch response valid
// instr_rdata_o   out  32       fetch response data (lane-selected)
// instr_err_o     out  1        fetch bus error
// data_req_i      in   1        LSU request
// data_gnt_o      out  1        LSU grant
// data_addr_i     in   32       LSU address
// data_we_i       in   1        LSU write enable
// data_be_i       in   MEM_W/8  LSU byte enables
// data_wdata_i    in   MEM_W    LSU write data
// data_rvalid_o   out  1        LSU response valid
// data_rdata_o    out  MEM_W    LSU response data
// data_err_o      out  1        LSU bus error
// mem_req_o       out  1        memory request
// mem_gnt_i       in   1        memory grant
// mem_addr_o      out  32       memory address
// mem_we_o        out  1        memory write enable (0 for fetch)
// mem_be_o        out  MEM_W/8  byte enables (all ones for fetch)
// mem_wdata_o     out  MEM_W    write data
// mem_rvalid_i    in   1        memory response valid, in request order
// mem_err_i       in   1        memory error, qualified by mem_rvalid_i
// mem_rdata_i     in   MEM_W    memory read data
// outstanding_o   out  clog2(DEPTH)+1  count of in-flight requests
// spurious_o      out  1        sticky: mem_rvalid_i seen while FIFO empty
// BEHAVIOUR
// - Reset: FIFO empty; outstanding_o=0; spurious_o=0; starve counter=0.
//   All gnt/rvalid/err outputs are 0 while reset is applied.
// - full = (count==DEPTH), taken from the register. A pop in the same cycle does not unblock.
//   When full, mem_req_o=0 and both grants are 0.
// - sel_instr = instr_req_i & (~data_req_i | starve==STARVE_MAX).
// - mem_req_o = (instr_req_i|data_req_i) & ~full.
//   mem_* fields come from the selected source. Fetch drives we=0, be='1, wdata=0.
// - Grants are combinational: instr_gnt_o = mem_req_o & mem_gnt_i & sel_instr.
//   data_gnt_o uses the same condition with ~sel_instr.
// - Starve counter: increments on data grant while instr_req_i=1; clears on fetch grant.
//   Holds otherwise. Saturates at STARVE_MAX.
// - Push on any grant: entry {src, addr[clog2(MEM_W/8)-1:2]}. Pop on mem_rvalid_i.
//   Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
// - Response routing is combinational from the FIFO head; zero added latency.
//   - instr_rvalid_o = mem_rvalid_i & ~empty & ~head.src
//   - data_rvalid_o  = mem_rvalid_i & ~empty &  head.src
//   - *_err_o = mem_err_i & the matching rvalid.
//   - instr_rdata_o = mem_rdata_i[head.lane*32 +: 32]. For MEM_W=32, lane is always 0.
//   - data_rdata_o = mem_rdata_i.
// - A response is never consumed in its grant cycle; memory returns rvalid >= 1 cycle after gnt.
// - mem_rvalid_i with FIFO empty: no rvalid out, no pop, spurious_o set until reset.
// - Reset mid-transaction flushes the FIFO. Late responses to pre-reset requests set spurious_o.
// TESTING
// 1. Only fetch at 0x80; gnt; rvalid next cycle with 0xDEADBEEF.
//    -> instr_rvalid_o=1, instr_rdata_o=0xDEADBEEF, outstanding 1->0.
// 2. Both request every cycle, mem_gnt_i=1, STARVE_MAX=4.
//    -> grant pattern D,D,D,D,I repeating.
// 3. Issue 8 grants with no rvalid (DEPTH=8). -> 9th cycle mem_req_o=0, outstanding_o=8.
//    Then one rvalid -> req resumes the next cycle.
// 4. Interleave I,D,I grants, then 3 rvalids with 0x1,0x2,0x3.
//    -> instr gets 0x1, data 0x2, instr 0x3. Errors route likewise.
// 5. MEM_W=64: fetch at 0x84; rdata 0x11112222_33334444. -> instr_rdata_o=0x11112222.
// 6. rvalid with FIFO empty -> spurious_o=1, no rvalid out.
//    Reset with 2 outstanding -> outstanding_o=0.

Source files
------------

// File: rtl/obi_mem_arbiter.sv
// Shares one memory port between the OBI fetch and LSU ports. Data wins by default, a
// starvation counter forces fetch through, and an in-order FIFO routes responses home.
module obi_mem_arbiter #(
    parameter int MEM_W      = 32,
    parameter int DEPTH      = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       instr_req_i,
    output logic                       instr_gnt_o,
    input  logic [31:0]                instr_addr_i,
    output logic                       instr_rvalid_o,
    output logic [31:0]                instr_rdata_o,
    output logic                       instr_err_o,
    input  logic                       data_req_i,
    output logic                       data_gnt_o,
    input  logic [31:0]                data_addr_i,
    input  logic                       data_we_i,
    input  logic [MEM_W/8-1:0]         data_be_i,
    input  logic [MEM_W-1:0]           data_wdata_i,
    output logic                       data_rvalid_o,
    output logic [MEM_W-1:0]           data_rdata_o,
    output logic                       data_err_o,
    output logic                       mem_req_o,
    input  logic                       mem_gnt_i,
    output logic [31:0]                mem_addr_o,
    output logic                       mem_we_o,
    output logic [MEM_W/8-1:0]         mem_be_o,
    output logic [MEM_W-1:0]           mem_wdata_o,
    input  logic                       mem_rvalid_i,
    input  logic                       mem_err_i,
    input  logic [MEM_W-1:0]           mem_rdata_i,
    output logic [$clog2(DEPTH):0]     outstanding_o,
    output logic                       spurious_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LANES = MEM_W / 32;
    localparam int ST_W  = $clog2(STARVE_MAX + 1);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [ST_W-1:0]  r_starve;
    logic             r_spurious;
    logic             r_src [DEPTH];   // 1 = data, 0 = fetch

    logic w_full;
    logic w_empty;
    logic w_sel_instr;
    logic w_go;
    logic w_push;
    logic w_pop;
    logic w_head_src;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // Fetch wins only when data is idle or fetch has been passed over STARVE_MAX times.
    assign w_sel_instr = instr_req_i & (~data_req_i | (r_starve == ST_W'(STARVE_MAX)));

    assign mem_req_o   = (instr_req_i | data_req_i) & ~w_full & ~rst_i;
    assign mem_addr_o  = w_sel_instr ? instr_addr_i : data_addr_i;
    assign mem_we_o    = ~w_sel_instr & data_we_i;
    assign mem_be_o    = w_sel_instr ? '1 : data_be_i;
    assign mem_wdata_o = w_sel_instr ? '0 : data_wdata_i;

    assign w_go        = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = w_go & w_sel_instr;
    assign data_gnt_o  = w_go & ~w_sel_instr;
    assign w_push      = w_go;

    assign w_head_src     = r_src[r_rd_ptr];
    assign w_pop          = mem_rvalid_i & ~w_empty & ~rst_i;
    assign instr_rvalid_o = w_pop & ~w_head_src;
    assign data_rvalid_o  = w_pop & w_head_src;
    assign instr_err_o    = mem_err_i & instr_rvalid_o;
    assign data_err_o     = mem_err_i & data_rvalid_o;
    assign data_rdata_o   = mem_rdata_i;

    assign outstanding_o = r_count;
    assign spurious_o    = r_spurious;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_src[r_wr_ptr] <= data_gnt_o;
        end
    end

    generate
        if (LANES > 1) begin : g_lanes
            localparam int LW = $clog2(LANES);
            logic [LW-1:0] r_lane [DEPTH];

            always_ff @(posedge clk_i) begin
                if (w_push) begin
                    r_lane[r_wr_ptr] <= mem_addr_o[2 +: LW];
                end
            end

            assign instr_rdata_o = mem_rdata_i[{r_lane[r_rd_ptr], 5'b0} +: 32];
        end else begin : g_one_lane
            assign instr_rdata_o = mem_rdata_i[31:0];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_starve   <= '0;
            r_spurious <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push & ~w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (~w_push & w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (instr_gnt_o) begin
                r_starve <= '0;
            end else if (data_gnt_o & instr_req_i & (r_starve != ST_W'(STARVE_MAX))) begin
                r_starve <= r_starve + 1'b1;
            end
            if (mem_rvalid_i & w_empty) begin
                r_spurious <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Bench for obi_mem_arbiter (64-bit memory): directed vector table, hand-written corner
// sequences, then random traffic compared against a queue-based reference model.
module tb_obi_mem_arbiter;

    localparam int MEM_W      = 64;
    localparam int DEPTH      = 8;
    localparam int STARVE_MAX = 4;
    localparam int BE_W       = MEM_W / 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             ireq, igt, irv, ierr;
    logic [31:0]      iaddr, irdata;
    logic             dreq, dgt, dwe, drv, derr;
    logic [31:0]      daddr;
    logic [BE_W-1:0]  dbe;
    logic [MEM_W-1:0] dwdata, drdata;
    logic             mreq, mg, mwe, mrv, merr;
    logic [31:0]      maddr;
    logic [BE_W-1:0]  mbe;
    logic [MEM_W-1:0] mwdata, mrdata;
    logic [$clog2(DEPTH):0] outst;
    logic             spur;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    obi_mem_arbiter #(.MEM_W(MEM_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(ireq), .instr_gnt_o(igt), .instr_addr_i(iaddr),
        .instr_rvalid_o(irv), .instr_rdata_o(irdata), .instr_err_o(ierr),
        .data_req_i(dreq), .data_gnt_o(dgt), .data_addr_i(daddr), .data_we_i(dwe),
        .data_be_i(dbe), .data_wdata_i(dwdata), .data_rvalid_o(drv),
        .data_rdata_o(drdata), .data_err_o(derr),
        .mem_req_o(mreq), .mem_gnt_i(mg), .mem_addr_o(maddr), .mem_we_o(mwe),
        .mem_be_o(mbe), .mem_wdata_o(mwdata), .mem_rvalid_i(mrv), .mem_err_i(merr),
        .mem_rdata_i(mrdata), .outstanding_o(outst), .spurious_o(spur)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        ireq = 0; iaddr = '0; dreq = 0; daddr = '0; dwe = 0; dbe = '0; dwdata = '0;
        mg = 0; mrv = 0; merr = 0; mrdata = '0;
    endtask

    // Reference model state: queue of outstanding sources and lanes.
    typedef struct { bit is_data; int lane; } ent_t;
    ent_t q[$];
    int   m_starve;
    bit   m_spur;

    task automatic model_reset();
        q.delete();
        m_starve = 0;
        m_spur   = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; idle();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    // Checks current-cycle outputs against the rules, then advances the model one clock.
    task automatic model_cycle();
        bit   full, req_exp, sel, ig, dg, irv_e, drv_e;
        ent_t e;
        full    = (q.size() == DEPTH);
        req_exp = (ireq || dreq) && !full;
        sel     = ireq && (!dreq || m_starve == STARVE_MAX);
        ig      = req_exp && mg && sel;
        dg      = req_exp && mg && !sel;
        chk("mem_req", mreq, req_exp);
        chk("instr_gnt", igt, ig);
        chk("data_gnt", dgt, dg);
        if (req_exp) begin
            chk("mem_addr", maddr, sel ? iaddr : daddr);
            chk("mem_we", mwe, sel ? 1'b0 : dwe);
            chk("mem_be", mbe, sel ? {BE_W{1'b1}} : dbe);
            chk("mem_wdata", mwdata, sel ? '0 : dwdata);
        end
        irv_e = mrv && q.size() > 0 && !q[0].is_data;
        drv_e = mrv && q.size() > 0 && q[0].is_data;
        chk("instr_rvalid", irv, irv_e);
        chk("data_rvalid", drv, drv_e);
        chk("instr_err", ierr, irv_e && merr);
        chk("data_err", derr, drv_e && merr);
        if (irv_e) begin
            chk("instr_rdata", irdata, 32'(mrdata >> (32 * q[0].lane)));
            $display("rand: fetch rsp lane %0d data %08h", q[0].lane, irdata);
        end
        if (drv_e) begin
            chk("data_rdata", drdata, mrdata);
            $display("rand: data rsp %016h err %0d", drdata, derr);
        end
        chk("outstanding", outst, q.size());
        chk("spurious", spur, m_spur);
        if (mrv) begin
            if (q.size() > 0) void'(q.pop_front());
            else m_spur = 1;
        end
        if (ig || dg) begin
            e.is_data = dg;
            e.lane    = ((sel ? iaddr : daddr) >> 2) % (MEM_W / 32);
            q.push_back(e);
        end
        if (ig) m_starve = 0;
        else if (dg && ireq && m_starve < STARVE_MAX) m_starve++;
    endtask

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        g;
        logic        rv;
        logic        er;
        logic [63:0] rd;
        logic        e_ig, e_dg, e_irv, e_ierr, e_drv, e_derr;
        logic [31:0] e_ird;
        logic [63:0] e_drd;
        int          e_out;
    } vec_t;

    vec_t tbl[13];

    initial begin
        rst = 1; idle();

        //            ir ia     dr g  rv er rd                       ig dg irv ie drv de ird           drd  out
        tbl[0]  = '{1, 32'h80, 0, 1, 0, 0, 64'h0,                   1, 0, 0, 0, 0, 0, 32'h0,        64'h0, 0};
        tbl[1]  = '{0, 32'h0,  0, 0, 1, 0, 64'hDEADBEEF,            0, 0, 1, 0, 0, 0, 32'hDEADBEEF, 64'h0, 1};
        tbl[2]  = '{0, 32'h0,  0, 0, 0, 0, 64'h0,                   0, 0, 0, 0, 0, 0, 32'h0,        64'h0, 0};
        tbl[3]  = '{1, 32'h0,  0, 1, 0, 0, 64'h0,                   1, 0, 0, 0, 0, 0, 32'h0,        64'h0, 0};
        tbl[4]  = '{0, 32'h0,  1, 1, 0, 0, 64'h0,                   0, 1, 0, 0, 0, 0, 32'h0,        64'h0, 1};
        tbl[5]  = '{1, 32'h4,  0, 1, 0, 0, 64'h0,                   1, 0, 0, 0, 0, 0, 32'h0,        64'h0, 2};
        tbl[6]  = '{0, 32'h0,  0, 0, 1, 0, 64'h1,                   0, 0, 1, 0, 0, 0, 32'h1,        64'h0, 3};
        tbl[7]  = '{0, 32'h0,  0, 0, 1, 1, 64'h2,                   0, 0, 0, 0, 1, 1, 32'h0,        64'h2, 2};
        tbl[8]  = '{0, 32'h0,  0, 0, 1, 1, 64'h3_0000_0000,         0, 0, 1, 1, 0, 0, 32'h3,        64'h0, 1};
        tbl[9]  = '{0, 32'h0,  0, 0, 0, 0, 64'h0,                   0, 0, 0, 0, 0, 0, 32'h0,        64'h0, 0};
        tbl[10] = '{1, 32'h84, 0, 1, 0, 0, 64'h0,                   1, 0, 0, 0, 0, 0, 32'h0,        64'h0, 0};
        tbl[11] = '{0, 32'h0,  0, 0, 1, 0, 64'h11112222_33334444,   0, 0, 1, 0, 0, 0, 32'h11112222, 64'h0, 1};
        tbl[12] = '{0, 32'h0,  0, 0, 0, 0, 64'h0,                   0, 0, 0, 0, 0, 0, 32'h0,        64'h0, 0};

        do_reset();
        @(negedge clk); #1;
        chk("reset outstanding", outst, 0);
        chk("reset spurious", spur, 0);
        chk("reset mem_req", mreq, 0);

        // Vector table: single fetch, interleaved I/D/I with error routing, 64-bit lane pick.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            idle();
            ireq = tbl[i].ir; iaddr = tbl[i].ia; dreq = tbl[i].dr; daddr = 32'h100;
            dbe = '1; mg = tbl[i].g; mrv = tbl[i].rv; merr = tbl[i].er; mrdata = tbl[i].rd;
            #1;
            chk($sformatf("v%0d instr_gnt", i), igt, tbl[i].e_ig);
            chk($sformatf("v%0d data_gnt", i), dgt, tbl[i].e_dg);
            chk($sformatf("v%0d instr_rvalid", i), irv, tbl[i].e_irv);
            chk($sformatf("v%0d instr_err", i), ierr, tbl[i].e_ierr);
            chk($sformatf("v%0d data_rvalid", i), drv, tbl[i].e_drv);
            chk($sformatf("v%0d data_err", i), derr, tbl[i].e_derr);
            chk($sformatf("v%0d outstanding", i), outst, tbl[i].e_out);
            if (tbl[i].e_irv) chk($sformatf("v%0d instr_rdata", i), irdata, tbl[i].e_ird);
            if (tbl[i].e_drv) chk($sformatf("v%0d data_rdata", i), drdata, tbl[i].e_drd);
            $display("vec %0d: igt=%0d dgt=%0d irv=%0d drv=%0d ird=%08h out=%0d",
                     i, igt, dgt, irv, drv, irdata, outst);
        end

        // Starvation: both request every cycle, grants follow D,D,D,D,I.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            idle();
            ireq = 1; dreq = 1; mg = 1; mrv = (i > 0); daddr = 32'h200; iaddr = 32'h300;
            #1;
            chk($sformatf("starve%0d instr_gnt", i), igt, (i % 5) == 4);
            chk($sformatf("starve%0d data_gnt", i), dgt, (i % 5) != 4);
            $display("starve %0d: grant %s", i, igt ? "I" : (dgt ? "D" : "-"));
        end

        // Fill to DEPTH, then a pop in the full cycle must not unblock until the next one.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            idle(); dreq = 1; mg = 1;
            #1;
            chk($sformatf("fill%0d data_gnt", i), dgt, 1);
            chk($sformatf("fill%0d outstanding", i), outst, i);
        end
        @(negedge clk);
        idle(); dreq = 1; mg = 1;
        #1;
        chk("full mem_req", mreq, 0);
        chk("full data_gnt", dgt, 0);
        chk("full outstanding", outst, DEPTH);
        @(negedge clk);
        idle(); dreq = 1; mg = 1; mrv = 1;
        #1;
        chk("full+pop mem_req", mreq, 0);
        chk("full+pop data_rvalid", drv, 1);
        @(negedge clk);
        idle(); dreq = 1; mg = 1;
        #1;
        chk("resume mem_req", mreq, 1);
        chk("resume data_gnt", dgt, 1);
        chk("resume outstanding", outst, DEPTH - 1);
        $display("full: resumed with outstanding=%0d", outst);

        // Spurious response, then reset with two in flight and a late response.
        do_reset();
        @(negedge clk);
        idle(); mrv = 1;
        #1;
        chk("spur instr_rvalid", irv, 0);
        chk("spur data_rvalid", drv, 0);
        @(negedge clk);
        idle();
        #1;
        chk("spur sticky", spur, 1);
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            idle(); ireq = 1; mg = 1;
        end
        @(negedge clk);
        idle();
        #1;
        chk("pre-reset outstanding", outst, 2);
        @(negedge clk);
        idle(); rst = 1; ireq = 1; dreq = 1; mg = 1; mrv = 1;
        #1;
        chk("in-reset instr_gnt", igt, 0);
        chk("in-reset data_gnt", dgt, 0);
        chk("in-reset instr_rvalid", irv, 0);
        chk("in-reset data_rvalid", drv, 0);
        @(negedge clk);
        rst = 0; idle();
        #1;
        chk("post-reset outstanding", outst, 0);
        chk("post-reset spurious", spur, 0);
        @(negedge clk);
        idle(); mrv = 1;
        #1;
        chk("late rsp instr_rvalid", irv, 0);
        @(negedge clk);
        idle();
        #1;
        chk("late rsp spurious", spur, 1);
        $display("spurious: flag=%0d after late response", spur);

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ireq   = ($urandom_range(0, 3) != 0);
            iaddr  = $urandom & 32'hFFFF_FFFC;
            dreq   = ($urandom_range(0, 2) != 0);
            daddr  = $urandom;
            dwe    = $urandom_range(0, 1);
            dbe    = BE_W'($urandom);
            dwdata = {$urandom, $urandom};
            mg     = ($urandom_range(0, 3) != 0);
            mrv    = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            merr   = mrv && ($urandom_range(0, 7) == 0);
            mrdata = {$urandom, $urandom};
            #1;
            model_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
